// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the up/down counter family.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // A power-of-two modulus lets the counter wrap through natural overflow.
  function automatic bit mod_is_pow2(input int width, input longint modulus);
    return modulus == (longint'(1) << width);
  endfunction

endpackage

// File: rtl/mod_updown_counter_count_next.sv
// Combinational next-count logic: step, terminal detection and wrap flag.
module count_next
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 256
) (
  input  logic [WIDTH-1:0] value,
  input  logic             up,
  input  logic             saturate,
  input  logic             enable,
  output logic [WIDTH-1:0] nextValue,
  output logic             atTerminal,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXVAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam bit               POW2   = mod_is_pow2(WIDTH, MODULUS);

  logic [WIDTH-1:0] terminalValue;
  logic [WIDTH-1:0] stepValue;
  logic [WIDTH-1:0] wrapValue;

  assign terminalValue = (up == DIR_UP) ? MAXVAL : '0;
  assign atTerminal    = (value == terminalValue);
  assign stepValue     = (up == DIR_UP) ? value + ONE : value - ONE;
  assign wrapValue     = POW2 ? stepValue : ((up == DIR_UP) ? '0 : MAXVAL);

  always_comb begin
    nextValue = value;
    wrap      = 1'b0;
    if (enable) begin
      if (!atTerminal) begin
        nextValue = stepValue;
      end else if (saturate == MODE_WRAP) begin
        nextValue = wrapValue;
        wrap      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus, clamped parallel load,
// wrap/saturate mode and a combinational cascade output.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 256
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Enable,
  input  logic             Up,
  input  logic             Saturate,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] CounterValue,
  output logic             TerminalCount,
  output logic             Wrapped
);

  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
      MODULUS > (longint'(1) << WIDTH)) begin : gBadParams
    $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] MAXVAL = WIDTH'(MODULUS - 1);
  localparam logic [63:0]      MOD64  = 64'(MODULUS);

  logic [WIDTH-1:0] nextValue;
  logic [WIDTH-1:0] loadClamped;
  logic             atTerminal;
  logic             wrap;

  count_next #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) uNext (
    .value     (CounterValue),
    .up        (Up),
    .saturate  (Saturate),
    .enable    (Enable),
    .nextValue (nextValue),
    .atTerminal(atTerminal),
    .wrap      (wrap)
  );

  // Out-of-range loads pin to the top of the count range so the register
  // never holds a value outside 0..MODULUS-1.
  assign loadClamped   = (64'(LoadValue) >= MOD64) ? MAXVAL : LoadValue;
  assign TerminalCount = Enable & atTerminal;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      CounterValue <= '0;
      Wrapped      <= 1'b0;
    end else if (Load) begin
      CounterValue <= loadClamped;
      Wrapped      <= 1'b0;
    end else begin
      CounterValue <= nextValue;
      Wrapped      <= wrap;
    end
  end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous up/down counter with programmable modulus, parallel load, wrap or saturate mode, and a carry/borrow output for cascading. It is the general-purpose counter for the design's timing, dividing and event-counting paths, where the fixed 8-bit up-only T-flip-flop counter is too narrow or too rigid. Chained instances build wider or mixed-radix counters, for example BCD digits or hh:mm:ss.

## Interface
- `WIDTH`, default 8: counter width in bits; legal range 1–32.
- `MODULUS`, default 256: count range is 0..MODULUS-1; legal range 2..2^WIDTH; checked at elaboration.
- `Clock` in 1: sole clock; all state updates on its rising edge.
- `Clear` in 1: reset, synchronous and active-high; highest priority.
- `Enable` in 1: count enable; also the cascade input from a lower stage's `TerminalCount`.
- `Up` in 1: direction; 1 counts up, 0 counts down.
- `Saturate` in 1: mode; 0 wraps at the terminal value, 1 holds at the terminal value.
- `Load` in 1: parallel load strobe.
- `LoadValue` in WIDTH: value written when `Load`=1.
- `CounterValue` out WIDTH: current count, registered.
- `TerminalCount` out 1: combinational cascade carry/borrow.
- `Wrapped` out 1: registered one-cycle pulse on a wrap.

## Operation
- Terminal value by direction: MODULUS-1 when `Up`=1; 0 when `Up`=0.
- Priority per rising edge: `Clear` > `Load` > `Enable` > hold.
- `Clear`=1: `CounterValue`←0; `Wrapped`←0.
- `Load`=1, no Clear:
  - `CounterValue`←`LoadValue` when `LoadValue` < MODULUS.
  - `CounterValue`←MODULUS-1 when `LoadValue` ≥ MODULUS (clamp).
  - `Wrapped`←0 regardless of `Enable`.
- `Enable`=1, not at terminal: `CounterValue`←value+1 (up) or value−1 (down); `Wrapped`←0.
- `Enable`=1, at terminal, `Saturate`=0:
  - Up: `CounterValue`←0.
  - Down: `CounterValue`←MODULUS-1.
  - `Wrapped`←1.
- `Enable`=1, at terminal, `Saturate`=1: `CounterValue` holds; `Wrapped`←0.
- `Enable`=0: `CounterValue` holds; `Wrapped`←0.
- `TerminalCount` = `Enable` AND (`CounterValue` == terminal value for the current `Up`).
  - Independent of `Saturate`, `Load` and `Clear`.
  - Feeds the next stage's `Enable`, so the stages of a chain advance together.
- Arithmetic is WIDTH bits, unsigned. No intermediate value ever leaves 0..MODULUS-1.
  - With MODULUS=2^WIDTH, natural overflow gives the same result as an explicit compare.
- `Up` and `Saturate` may change on any cycle. The new value applies to the next edge and immediately to `TerminalCount`.

## Timing
- Output values after `Clear`: `CounterValue`=0, `Wrapped`=0. `TerminalCount`=0 unless `Enable`=1 and `Up`=0.
- Count, load and clear latency: 1 clock. The new `CounterValue` is visible after the edge that samples the request.
- `Wrapped` is aligned with the wrapped `CounterValue`: it is high in exactly the cycle the counter shows 0 (up) or MODULUS-1 (down) after a wrap.
- `TerminalCount` has zero latency and is combinational from the registered value plus `Enable` and `Up`. Cascade depth adds only gate delay.
- A `Clear` asserted mid-count takes effect on the next edge. Any pending `Load`, `Enable` or wrap is discarded.
- Continuous `Enable` in wrap mode gives one `Wrapped` pulse every MODULUS cycles.

## Structure
- Package `counter_pkg` holds the following.
  - Mode encoding constants: `MODE_WRAP`=0, `MODE_SAT`=1.
  - Direction constants: `DIR_DOWN`=0, `DIR_UP`=1.
  - An elaboration function `mod_is_pow2(WIDTH, MODULUS)` that selects the compare-free wrap path.
- One sub-module, `count_next`: purely combinational.
  - Inputs: current value, `Up`, `Saturate`, `Enable`.
  - Outputs: next value, the at-terminal flag, and the wrap flag.
- The top level holds the registers, the priority mux, the load clamp and the `TerminalCount` output.

## Test plan
All scenarios use WIDTH=4, MODULUS=10 unless stated.
1. `Clear` for 2 cycles, then `Enable`=1, `Up`=1 for 12 cycles → `CounterValue` 0,1…9,0,1. `TerminalCount`=1 only while the value is 9. `Wrapped`=1 only in the cycle showing 0 after 9.
2. Start at 0, `Up`=0, `Enable`=1 → `CounterValue` 9,8,7. `Wrapped`=1 in the cycle showing 9. `TerminalCount`=1 while the value is 0.
3. `Saturate`=1, up from 8 for 4 cycles → 9,9,9,9 with `Wrapped`=0 throughout and `TerminalCount`=1 from the first 9. Then `Up`=0 → 8 next.
4. `Load`=1, `LoadValue`=7, `Enable`=1 → 7 next cycle, `Wrapped`=0. `LoadValue`=13 → 9 (clamp).
5. At value 5, assert `Clear`, `Load` (`LoadValue`=3) and `Enable` together → 0 next cycle, `Wrapped`=0. Then at value 9, `Enable`=0 → value holds and `TerminalCount`=0.
6. Default parameters, two stages cascaded (low stage's `TerminalCount` drives high stage's `Enable`) → after 256 enabled cycles the high stage reads 1 and the low stage reads 0. Low stage's `Wrapped` pulses once.
